// File: rtl/bus_bridge.sv
// Bidirectional nibble-bus responder: forwards whichever side leaves idle,
// with direction arbitration, turnaround gap and sticky collision flag.
module bus_bridge #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] IDLE_VAL    = 4'hF,
  parameter int               TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] left_in,
  output logic [WIDTH-1:0] left_out,
  output logic             left_oe,
  input  logic [WIDTH-1:0] right_in,
  output logic [WIDTH-1:0] right_out,
  output logic             right_oe,
  output logic [1:0]       dir,
  output logic             collision,
  output logic [7:0]       xfer_cnt
);

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_L2R  = 2'b01,
    S_R2L  = 2'b10,
    S_TURN = 2'b11
  } state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_left_q, r_right_q;
  logic [WIDTH-1:0] r_left_out, w_left_out_nx;
  logic [WIDTH-1:0] r_right_out, w_right_out_nx;
  logic             r_left_oe, w_left_oe_nx;
  logic             r_right_oe, w_right_oe_nx;
  logic             r_coll, w_coll_nx;
  logic [7:0]       r_cnt, w_cnt_nx;
  logic [TW-1:0]    r_tcnt, w_tcnt_nx;
  logic             w_l_act, w_r_act;

  assign w_l_act = (r_left_q != IDLE_VAL);
  assign w_r_act = (r_right_q != IDLE_VAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_left_q    <= IDLE_VAL;
      r_right_q   <= IDLE_VAL;
      r_left_out  <= IDLE_VAL;
      r_right_out <= IDLE_VAL;
      r_left_oe   <= 1'b0;
      r_right_oe  <= 1'b0;
      r_coll      <= 1'b0;
      r_cnt       <= 8'd0;
      r_tcnt      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_left_q    <= left_in;
      r_right_q   <= right_in;
      r_left_out  <= w_left_out_nx;
      r_right_out <= w_right_out_nx;
      r_left_oe   <= w_left_oe_nx;
      r_right_oe  <= w_right_oe_nx;
      r_coll      <= w_coll_nx;
      r_cnt       <= w_cnt_nx;
      r_tcnt      <= w_tcnt_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_left_out_nx  = r_left_out;
    w_right_out_nx = r_right_out;
    w_left_oe_nx   = r_left_oe;
    w_right_oe_nx  = r_right_oe;
    w_coll_nx      = r_coll;
    w_cnt_nx       = r_cnt;
    w_tcnt_nx      = r_tcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_l_act && !w_r_act) begin
          w_state_nx     = S_L2R;
          w_right_oe_nx  = 1'b1;
          w_right_out_nx = r_left_q;
          w_cnt_nx       = r_cnt + 8'd1;
        end else if (w_r_act && !w_l_act) begin
          w_state_nx    = S_R2L;
          w_left_oe_nx  = 1'b1;
          w_left_out_nx = r_right_q;
          w_cnt_nx      = r_cnt + 8'd1;
        end else if (w_l_act && w_r_act) begin
          w_coll_nx = 1'b1;
        end
      end
      // The driven side only reads back our own drive, so it is ignored
      S_L2R: begin
        if (w_l_act) begin
          w_right_out_nx = r_left_q;
        end else begin
          w_state_nx     = S_TURN;
          w_right_oe_nx  = 1'b0;
          w_right_out_nx = IDLE_VAL;
          w_tcnt_nx      = TW'(TURN_CYCLES - 1);
        end
      end
      S_R2L: begin
        if (w_r_act) begin
          w_left_out_nx = r_right_q;
        end else begin
          w_state_nx    = S_TURN;
          w_left_oe_nx  = 1'b0;
          w_left_out_nx = IDLE_VAL;
          w_tcnt_nx     = TW'(TURN_CYCLES - 1);
        end
      end
      S_TURN: begin
        if (r_tcnt == '0) w_state_nx = S_IDLE;
        else              w_tcnt_nx  = r_tcnt - 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign left_out  = r_left_out;
  assign left_oe   = r_left_oe;
  assign right_out = r_right_out;
  assign right_oe  = r_right_oe;
  assign dir       = r_state;
  assign collision = r_coll;
  assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_bus_bridge.sv
// Directed and randomized checks of bus_bridge against an
// ownership/gap model of the bus.
module tb_bus_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] left_in = 4'hF;
  logic [3:0] right_in = 4'hF;
  logic [3:0] left_out, right_out;
  logic       left_oe, right_oe;
  logic [1:0] dir;
  logic       collision;
  logic [7:0] xfer_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who owns the bus (0 none, 1 left, 2 right, 3 gap)
  int         m_own = 0;
  int         m_gap = 0;
  logic [3:0] m_lq = 4'hF, m_rq = 4'hF;
  logic [3:0] m_lout = 4'hF, m_rout = 4'hF;
  logic       m_loe = 0, m_roe = 0, m_col = 0;
  int         m_cnt = 0;

  bus_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .left_in   (left_in),
    .left_out  (left_out),
    .left_oe   (left_oe),
    .right_in  (right_in),
    .right_out (right_out),
    .right_oe  (right_oe),
    .dir       (dir),
    .collision (collision),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model(input logic [3:0] li, input logic [3:0] ri,
                       input logic rn);
    bit la, ra;
    if (!rn) begin
      m_own = 0; m_gap = 0; m_lq = 4'hF; m_rq = 4'hF;
      m_lout = 4'hF; m_rout = 4'hF; m_loe = 0; m_roe = 0;
      m_col = 0; m_cnt = 0;
      return;
    end
    la = (m_lq != 4'hF);
    ra = (m_rq != 4'hF);
    if (m_own == 0) begin
      if (la && !ra) begin
        m_own = 1; m_roe = 1; m_rout = m_lq; m_cnt = (m_cnt + 1) % 256;
      end else if (ra && !la) begin
        m_own = 2; m_loe = 1; m_lout = m_rq; m_cnt = (m_cnt + 1) % 256;
      end else if (la && ra) begin
        m_col = 1;
      end
    end else if (m_own == 1) begin
      if (la) m_rout = m_lq;
      else begin m_own = 3; m_gap = 2; m_roe = 0; m_rout = 4'hF; end
    end else if (m_own == 2) begin
      if (ra) m_lout = m_rq;
      else begin m_own = 3; m_gap = 2; m_loe = 0; m_lout = 4'hF; end
    end else begin
      m_gap = m_gap - 1;
      if (m_gap == 0) m_own = 0;
    end
    m_lq = li;
    m_rq = ri;
  endtask

  task automatic tick();
    logic [3:0] li, ri;
    logic rn;
    li = left_in; ri = right_in; rn = rst_n;
    @(posedge clk); #1;
    model(li, ri, rn);
    chk("no_dual_oe", {7'd0, left_oe & right_oe}, 8'd0);
  endtask

  task automatic check_all();
    chk("m_left_out", {4'd0, left_out}, {4'd0, m_lout});
    chk("m_right_out", {4'd0, right_out}, {4'd0, m_rout});
    chk("m_left_oe", {7'd0, left_oe}, {7'd0, m_loe});
    chk("m_right_oe", {7'd0, right_oe}, {7'd0, m_roe});
    chk("m_dir", {6'd0, dir}, 8'(m_own));
    chk("m_collision", {7'd0, collision}, {7'd0, m_col});
    chk("m_xfer_cnt", xfer_cnt, 8'(m_cnt));
  endtask

  initial begin
    // Reset held two cycles with the left side active
    rst_n = 0; left_in = 4'h3; right_in = 4'hF;
    tick(); tick();
    chk("rst_left_oe", {7'd0, left_oe}, 8'd0);
    chk("rst_right_oe", {7'd0, right_oe}, 8'd0);
    chk("rst_dir", {6'd0, dir}, 8'd0);
    chk("rst_cnt", xfer_cnt, 8'd0);
    chk("rst_coll", {7'd0, collision}, 8'd0);
    chk("rst_left_out", {4'd0, left_out}, 8'hF);
    chk("rst_right_out", {4'd0, right_out}, 8'hF);
    rst_n = 1; left_in = 4'hF;
    tick(); tick();
    chk("idle_dir", {6'd0, dir}, 8'd0);

    // L2R
    left_in = 4'h5;
    tick();
    chk("l2r_k_roe", {7'd0, right_oe}, 8'd0);
    tick();
    chk("l2r_roe", {7'd0, right_oe}, 8'd1);
    chk("l2r_rout", {4'd0, right_out}, 8'h5);
    chk("l2r_dir", {6'd0, dir}, 8'd1);
    chk("l2r_cnt", xfer_cnt, 8'd1);
    left_in = 4'hA;
    tick();
    chk("l2r_rout_hold", {4'd0, right_out}, 8'h5);
    tick();
    chk("l2r_rout_a", {4'd0, right_out}, 8'hA);
    chk("l2r_loe", {7'd0, left_oe}, 8'd0);

    // Release and turnaround, right side requests during the gap
    left_in = 4'hF;
    tick();
    chk("rel_dir_l2r", {6'd0, dir}, 8'd1);
    tick();
    chk("turn1_dir", {6'd0, dir}, 8'd3);
    chk("turn1_roe", {7'd0, right_oe}, 8'd0);
    chk("turn1_rout", {4'd0, right_out}, 8'hF);
    right_in = 4'h6;
    tick();
    chk("turn2_dir", {6'd0, dir}, 8'd3);
    chk("turn2_loe", {7'd0, left_oe}, 8'd0);
    tick();
    chk("post_turn_dir", {6'd0, dir}, 8'd0);
    chk("post_turn_loe", {7'd0, left_oe}, 8'd0);
    tick();
    chk("r2l6_dir", {6'd0, dir}, 8'd2);
    chk("r2l6_lout", {4'd0, left_out}, 8'h6);
    chk("r2l6_cnt", xfer_cnt, 8'd2);
    right_in = 4'hF;
    repeat (4) tick();
    chk("r2l6_done", {6'd0, dir}, 8'd0);

    // R2L with C
    right_in = 4'hC;
    tick();
    chk("r2l_k_roe", {7'd0, right_oe}, 8'd0);
    tick();
    chk("r2l_loe", {7'd0, left_oe}, 8'd1);
    chk("r2l_lout", {4'd0, left_out}, 8'hC);
    chk("r2l_dir", {6'd0, dir}, 8'd2);
    chk("r2l_roe", {7'd0, right_oe}, 8'd0);
    chk("r2l_cnt", xfer_cnt, 8'd3);
    right_in = 4'hF;
    repeat (4) tick();
    chk("r2l_idle", {6'd0, dir}, 8'd0);
    chk("r2l_lout_rel", {4'd0, left_out}, 8'hF);

    // Collision
    left_in = 4'h1; right_in = 4'h2;
    tick(); tick();
    chk("col_flag", {7'd0, collision}, 8'd1);
    chk("col_loe", {7'd0, left_oe}, 8'd0);
    chk("col_roe", {7'd0, right_oe}, 8'd0);
    chk("col_dir", {6'd0, dir}, 8'd0);
    chk("col_cnt", xfer_cnt, 8'd3);
    left_in = 4'hF; right_in = 4'hF;
    tick(); tick(); tick();
    chk("col_sticky", {7'd0, collision}, 8'd1);
    chk("col_sticky_cnt", xfer_cnt, 8'd3);

    // Reset mid-transfer
    left_in = 4'h5;
    tick(); tick();
    chk("mid_roe_on", {7'd0, right_oe}, 8'd1);
    rst_n = 0;
    tick();
    chk("mid_rst_roe", {7'd0, right_oe}, 8'd0);
    chk("mid_rst_dir", {6'd0, dir}, 8'd0);
    chk("mid_rst_cnt", xfer_cnt, 8'd0);
    chk("mid_rst_coll", {7'd0, collision}, 8'd0);
    left_in = 4'hF; rst_n = 1;
    tick();

    // 256 transfers wrap the counter
    for (int i = 0; i < 256; i++) begin
      left_in = 4'(1 + (i % 14));
      tick();
      left_in = 4'hF;
      repeat (4) tick();
      if (i == 0) chk("wrap_first", xfer_cnt, 8'd1);
      if (i == 254) chk("wrap_255", xfer_cnt, 8'd255);
    end
    chk("wrap_zero", xfer_cnt, 8'd0);
    check_all();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        left_in = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 14));
      if ($urandom_range(0, 3) == 0)
        right_in = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 14));
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
